md5_lane_scheduler: RTL and testbench
=====================================

Name: md5_lane_scheduler

Overview:
Sequences and shares one job (target hash, character range, cycle budget) across NUM_LANES MD5 brute-force lanes. Each lane is a chunk generator feeding a 64-stage MD5 pipeline. Sits between the host command interface and the lane array. Latches configuration, holds the lanes in reset, releases them together, and counts issued candidates. It arbitrates simultaneous matches and reports FOUND or EXHAUSTED with the winning lane and its plaintext.

Parameters:
NUM_LANES, 4, number of cracker lanes; 1..16
PIPE_DEPTH, 64, MD5 pipeline latency in cycles, from chunk issue to a valid match flag
ARM_CYCLES, 4, cycles lane_reset is held asserted before release

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  high when a command is accepted this cycle
cmd_op  in  4  0 NOP, 1..4 SET_A..SET_D, 5 SET_RANGE, 6 SET_LIMIT, 7 START, 8 ABORT
cmd_data  in  32  command operand
expected_hash  out  128  {A,B,C,D} to all lanes
range_min  out  8  lowest character code; reset 8'h61
range_max  out  8  highest character code; reset 8'h7a
lane_reset  out  NUM_LANES  per-lane generator/comparator reset; all ones at reset
lane_match  in  NUM_LANES  lane's comparator hit; valid only while RUN
lane_text  in  128*NUM_LANES  plaintext aligned to lane_match, lane i at [128*i+:128]
busy  out  1  state is ARM, RUN or DRAIN
found  out  1  sticky match flag
exhausted  out  1  sticky budget-expired flag
found_lane  out  4  index of the winning lane
found_text  out  128  plaintext of the winning lane
cand_count  out  64  candidate cycles issued, summed over all lanes

Behaviour:
- States: IDLE, ARM, RUN, DRAIN, FOUND, EXHAUSTED.
- Reset (async) forces IDLE and the following values:
  - lane_reset all ones, found=0, exhausted=0, found_lane=0, found_text=0, cand_count=0.
  - expected_hash=0, range_min=8'h61, range_max=8'h7a, limit=32'hFFFFFFFF.
- cmd_ready:
  - Equals 1 in IDLE, FOUND and EXHAUSTED.
  - In ARM, RUN and DRAIN, cmd_ready=1 only when cmd_op is ABORT or NOP.
  - A command is accepted when cmd_valid&&cmd_ready. It takes effect on the next clk edge.
- SET_A..SET_D write expected_hash[127:96], [95:64], [63:32] and [31:0] respectively.
- SET_RANGE: range_min=cmd_data[7:0], range_max=cmd_data[15:8].
  - If min>max, the command is ignored and registers are unchanged.
- SET_LIMIT sets the 32-bit per-lane cycle budget. A value of 0 is treated as 1.
- START (from IDLE, FOUND or EXHAUSTED):
  - Clears found, exhausted, found_text, found_lane and cand_count.
  - Enters ARM with lane_reset all ones.
  - The ARM counter runs ARM_CYCLES cycles. Then lane_reset goes to 0 for all lanes in the same cycle, and the state goes to RUN.
- RUN:
  - Per-lane cycle counter increments every cycle.
  - cand_count increments by NUM_LANES every cycle; the 64-bit addition wraps.
  - Match checking is enabled only once the cycle counter >= PIPE_DEPTH, which masks pipeline fill garbage.
  - When the cycle counter reaches limit, enter DRAIN. lane_reset is not asserted, so in-flight candidates finish.
- DRAIN:
  - Runs PIPE_DEPTH cycles with match checking still enabled.
  - cand_count is frozen.
  - Timeout leads to EXHAUSTED: exhausted=1 and lane_reset all ones.
- Match (RUN or DRAIN, any lane_match bit set):
  - The lowest-index set lane wins (fixed priority).
  - found_lane and found_text latch that lane's values the same cycle.
  - Next state is FOUND: found=1 and lane_reset all ones.
  - Later or simultaneous matches are ignored.
- A match in the same cycle as limit/drain expiry takes priority, so FOUND wins.
- ABORT in ARM, RUN or DRAIN goes to IDLE with lane_reset all ones. found and exhausted stay 0, and cand_count is preserved.
  - ABORT elsewhere is a no-op.
- A START received while busy is not accepted (cmd_ready=0).
- Outputs are registered. found, exhausted and found_* change only at the stated transitions. busy is decoded from the state register.
- Reset asserted mid-RUN returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then SET_A..D with 2971bc83/9b41f6a4/955620c0/9067fbfd, SET_RANGE 0x7a61 -> expected_hash = those words, min=0x61, max=0x7a, state IDLE.
- START, NUM_LANES=4 -> lane_reset all ones for 4 cycles, then 0 together.
  - After 10 RUN cycles, cand_count=40 and busy=1.
- Force lane_match=4'b0110 at RUN cycle 70 with distinct lane_text -> found_lane=1, found_text=lane 1's text, found=1 next cycle, lane_reset all ones.
- SET_LIMIT 100, no matches -> DRAIN at RUN cycle 100, exhausted=1 after a further 64 cycles, cand_count=400.
- lane_match pulse at RUN cycle 10 (< PIPE_DEPTH) -> ignored; lane_match on the final DRAIN cycle -> FOUND, exhausted stays 0.
- ABORT mid-RUN -> IDLE next cycle, count preserved.
  - SET_RANGE 0x4161 (min>max) -> ignored.
  - Async reset pulse mid-RUN -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/md5_lane_scheduler_if.sv
// Host command bus for md5_lane_scheduler: one-cycle command strobe with same-cycle ready.
// The master drives cmd_valid/cmd_op/cmd_data; the slave answers with cmd_ready.
interface md5_lane_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/md5_lane_scheduler.sv
// Job sequencer for NUM_LANES MD5 brute-force lanes: config latch, arm/run/drain control, match arbitration.
// Commands take effect on the next edge; while busy only NOP/ABORT are accepted (cmd_ready low otherwise).
module md5_lane_scheduler #(
  parameter int NUM_LANES  = 4,
  parameter int PIPE_DEPTH = 64,
  parameter int ARM_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  md5_lane_scheduler_if.slave        cmd,
  output logic [127:0]               expected_hash,
  output logic [7:0]                 range_min,
  output logic [7:0]                 range_max,
  output logic [NUM_LANES-1:0]       lane_reset,
  input  logic [NUM_LANES-1:0]       lane_match,
  input  logic [128*NUM_LANES-1:0]   lane_text,
  output logic                       busy,
  output logic                       found,
  output logic                       exhausted,
  output logic [3:0]                 found_lane,
  output logic [127:0]               found_text,
  output logic [63:0]                cand_count
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_SET_A = 4'd1;
  localparam logic [3:0] OP_SET_B = 4'd2;
  localparam logic [3:0] OP_SET_C = 4'd3;
  localparam logic [3:0] OP_SET_D = 4'd4;
  localparam logic [3:0] OP_RANGE = 4'd5;
  localparam logic [3:0] OP_LIMIT = 4'd6;
  localparam logic [3:0] OP_START = 4'd7;
  localparam logic [3:0] OP_ABORT = 4'd8;

  localparam logic [31:0] ARM_LAST   = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(PIPE_DEPTH - 1);
  localparam logic [31:0] FILL_CYC   = 32'(PIPE_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_RUN, ST_DRAIN, ST_FOUND, ST_EXHAUSTED
  } state_t;

  state_t state_q, state_d;

  logic [31:0]  limit;
  logic [31:0]  arm_cnt;
  logic [31:0]  cyc_cnt;
  logic [31:0]  drain_cnt;

  logic         accept, start_go, abort_go;
  logic         match_en, match_hit, limit_hit, drain_done, arm_done;
  logic [3:0]   win_lane;
  logic [127:0] win_text;

  assign busy          = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign cmd.cmd_ready = !busy || (cmd.cmd_op == OP_NOP) || (cmd.cmd_op == OP_ABORT);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign start_go      = accept && !busy && (cmd.cmd_op == OP_START);
  assign abort_go      = accept && busy && (cmd.cmd_op == OP_ABORT);

  // Matches before the pipeline has filled are leftovers from reset, not real hits.
  assign match_en   = ((state_q == ST_RUN) && (cyc_cnt >= FILL_CYC)) || (state_q == ST_DRAIN);
  assign match_hit  = match_en && (|lane_match);
  assign limit_hit  = (state_q == ST_RUN) && (cyc_cnt == limit - 32'd1);
  assign drain_done = (state_q == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign arm_done   = (state_q == ST_ARM) && (arm_cnt == ARM_LAST);

  always_comb begin
    win_lane = '0;
    win_text = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_match[i]) begin
        win_lane = 4'(i);
        win_text = lane_text[128*i +: 128];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: if (start_go) state_d = ST_ARM;
      ST_ARM: begin
        if (abort_go)      state_d = ST_IDLE;
        else if (arm_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_go)       state_d = ST_IDLE;
        else if (match_hit) state_d = ST_FOUND;
        else if (limit_hit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_go)        state_d = ST_IDLE;
        else if (match_hit)  state_d = ST_FOUND;
        else if (drain_done) state_d = ST_EXHAUSTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_hash <= '0;
      range_min     <= 8'h61;
      range_max     <= 8'h7a;
      limit         <= 32'hFFFF_FFFF;
      lane_reset    <= '1;
      found         <= 1'b0;
      exhausted     <= 1'b0;
      found_lane    <= '0;
      found_text    <= '0;
      cand_count    <= '0;
      arm_cnt       <= '0;
      cyc_cnt       <= '0;
      drain_cnt     <= '0;
    end else begin
      if (accept && !busy) begin
        case (cmd.cmd_op)
          OP_SET_A: expected_hash[127:96] <= cmd.cmd_data;
          OP_SET_B: expected_hash[95:64]  <= cmd.cmd_data;
          OP_SET_C: expected_hash[63:32]  <= cmd.cmd_data;
          OP_SET_D: expected_hash[31:0]   <= cmd.cmd_data;
          OP_RANGE: begin
            if (cmd.cmd_data[7:0] <= cmd.cmd_data[15:8]) begin
              range_min <= cmd.cmd_data[7:0];
              range_max <= cmd.cmd_data[15:8];
            end
          end
          OP_LIMIT: limit <= (cmd.cmd_data == 32'd0) ? 32'd1 : cmd.cmd_data;
          default: ;
        endcase
      end

      arm_cnt   <= (state_q == ST_ARM)   ? arm_cnt + 32'd1   : 32'd0;
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 32'd1 : 32'd0;
      if (state_q == ST_RUN)      cyc_cnt <= cyc_cnt + 32'd1;
      else if (state_q == ST_ARM) cyc_cnt <= 32'd0;

      // Lanes only run while the job is live; every other state holds them in reset.
      lane_reset <= ((state_d == ST_RUN) || (state_d == ST_DRAIN)) ? '0 : '1;

      if (start_go) begin
        found      <= 1'b0;
        exhausted  <= 1'b0;
        found_lane <= '0;
        found_text <= '0;
        cand_count <= '0;
      end else begin
        if ((state_q == ST_RUN) && !abort_go)
          cand_count <= cand_count + 64'(NUM_LANES);
        if ((state_d == ST_FOUND) && (state_q != ST_FOUND)) begin
          found      <= 1'b1;
          found_lane <= win_lane;
          found_text <= win_text;
        end
        if ((state_d == ST_EXHAUSTED) && (state_q == ST_DRAIN))
          exhausted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md5_lane_scheduler.sv
// Directed bench for md5_lane_scheduler with NUM_LANES=4, PIPE_DEPTH=64, ARM_CYCLES=4.
module tb_md5_lane_scheduler;

  localparam int NL = 4;

  logic            clk;
  logic            reset;
  logic [127:0]    expected_hash;
  logic [7:0]      range_min, range_max;
  logic [NL-1:0]   lane_reset;
  logic [NL-1:0]   lane_match;
  logic [128*NL-1:0] lane_text;
  logic            busy, found, exhausted;
  logic [3:0]      found_lane;
  logic [127:0]    found_text;
  logic [63:0]     cand_count;

  int n_tests = 0;
  int n_fail  = 0;

  md5_lane_scheduler_if cmd_if ();

  md5_lane_scheduler #(.NUM_LANES(NL), .PIPE_DEPTH(64), .ARM_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if),
    .expected_hash (expected_hash),
    .range_min     (range_min),
    .range_max     (range_max),
    .lane_reset    (lane_reset),
    .lane_match    (lane_match),
    .lane_text     (lane_text),
    .busy          (busy),
    .found         (found),
    .exhausted     (exhausted),
    .found_lane    (found_lane),
    .found_text    (found_text),
    .cand_count    (cand_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [31:0] data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    tick(1);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 4'd0;
    cmd_if.cmd_data  = 32'd0;
  endtask

  // Issue START and wait for the lanes to be released; leaves the bench at RUN cycle 0.
  task automatic do_start(input string tag);
    int n;
    send_cmd(4'd7, 32'd0);
    n = 0;
    while (lane_reset != 4'b0000 && n < 20) begin
      check({tag, "_arm_hold"}, lane_reset, 4'b1111);
      tick(1);
      n++;
    end
    check({tag, "_arm_len"}, n, 4);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lane_reset"}, lane_reset, 4'b1111);
    check({tag, "_found"}, found, 1'b0);
    check({tag, "_exhausted"}, exhausted, 1'b0);
    check({tag, "_found_lane"}, found_lane, 4'd0);
    check({tag, "_found_text"}, found_text, 128'd0);
    check({tag, "_cand_count"}, cand_count, 64'd0);
    check({tag, "_hash"}, expected_hash, 128'd0);
    check({tag, "_min"}, range_min, 8'h61);
    check({tag, "_max"}, range_max, 8'h7a);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 4'd0;
    cmd_if.cmd_data  = 32'd0;
    lane_match = '0;
    for (int i = 0; i < NL; i++)
      lane_text[128*i +: 128] = {4{32'hC0DE_0000 + 32'(i)}};

    #2 reset = 1'b1;
    #20;
    check_reset_vals("rst");
    check("rst_cmd_ready", cmd_if.cmd_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // Configuration
    send_cmd(4'd1, 32'h2971bc83);
    send_cmd(4'd2, 32'h9b41f6a4);
    send_cmd(4'd3, 32'h955620c0);
    send_cmd(4'd4, 32'h9067fbfd);
    send_cmd(4'd5, 32'h0000_7a61);
    check("cfg_hash", expected_hash, 128'h2971bc83_9b41f6a4_955620c0_9067fbfd);
    check("cfg_min", range_min, 8'h61);
    check("cfg_max", range_max, 8'h7a);
    check("cfg_idle", busy, 1'b0);
    send_cmd(4'd5, 32'h0000_4161);
    check("range_bad_min", range_min, 8'h61);
    check("range_bad_max", range_max, 8'h7a);

    // START, then a match at RUN cycle 70 from lanes 1 and 2
    do_start("s1");
    check("s1_busy", busy, 1'b1);
    cmd_if.cmd_op = 4'd7;
    #1 check("rdy_start_busy", cmd_if.cmd_ready, 1'b0);
    cmd_if.cmd_op = 4'd0;
    #1 check("rdy_nop_busy", cmd_if.cmd_ready, 1'b1);
    cmd_if.cmd_op = 4'd8;
    #1 check("rdy_abort_busy", cmd_if.cmd_ready, 1'b1);
    cmd_if.cmd_op = 4'd1;
    #1 check("rdy_set_busy", cmd_if.cmd_ready, 1'b0);
    cmd_if.cmd_op = 4'd0;
    tick(10);
    check("run10_count", cand_count, 64'd40);
    check("run10_busy", busy, 1'b1);
    tick(60);
    check("run70_found_pre", found, 1'b0);
    lane_match = 4'b0110;
    tick(1);
    lane_match = 4'b0000;
    check("m70_found", found, 1'b1);
    check("m70_lane", found_lane, 4'd1);
    check("m70_text", found_text, 128'hC0DE0001_C0DE0001_C0DE0001_C0DE0001);
    check("m70_lane_reset", lane_reset, 4'b1111);
    check("m70_busy", busy, 1'b0);
    check("m70_count", cand_count, 64'd284);
    lane_match = 4'b0001;
    tick(1);
    lane_match = 4'b0000;
    check("late_match_lane", found_lane, 4'd1);

    // Budget of 100 cycles, early pulse ignored, exhaustion
    send_cmd(4'd6, 32'd100);
    do_start("s2");
    check("s2_found_clr", found, 1'b0);
    check("s2_text_clr", found_text, 128'd0);
    tick(10);
    lane_match = 4'b1111;
    tick(1);
    lane_match = 4'b0000;
    check("early_ignored", found, 1'b0);
    check("early_busy", busy, 1'b1);
    tick(89);
    check("drain_count", cand_count, 64'd400);
    check("drain_lanes_run", lane_reset, 4'b0000);
    tick(1);
    check("drain_frozen", cand_count, 64'd400);
    n = 1;
    while (!exhausted && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_len", n, 64);
    check("exh_flag", exhausted, 1'b1);
    check("exh_found", found, 1'b0);
    check("exh_lane_reset", lane_reset, 4'b1111);
    check("exh_count", cand_count, 64'd400);

    // Match on the final DRAIN cycle
    do_start("s3");
    check("s3_exh_clr", exhausted, 1'b0);
    check("s3_count_clr", cand_count, 64'd0);
    tick(163);
    check("s3_still_busy", busy, 1'b1);
    lane_match = 4'b1000;
    tick(1);
    lane_match = 4'b0000;
    check("lastdrain_found", found, 1'b1);
    check("lastdrain_exh", exhausted, 1'b0);
    check("lastdrain_lane", found_lane, 4'd3);
    check("lastdrain_text", found_text, 128'hC0DE0003_C0DE0003_C0DE0003_C0DE0003);

    // ABORT mid-RUN
    do_start("s4");
    tick(20);
    check("pre_abort_count", cand_count, 64'd80);
    send_cmd(4'd8, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_lane_reset", lane_reset, 4'b1111);
    check("abort_found", found, 1'b0);
    check("abort_exh", exhausted, 1'b0);
    check("abort_count", cand_count, 64'd80);
    send_cmd(4'd8, 32'd0);
    tick(3);
    check("idle_abort_count", cand_count, 64'd80);
    check("idle_abort_busy", busy, 1'b0);

    // Limit 0 behaves as a one-cycle budget
    send_cmd(4'd6, 32'd0);
    do_start("s5");
    tick(5);
    check("limit0_count", cand_count, 64'd4);
    check("limit0_busy", busy, 1'b1);
    send_cmd(4'd8, 32'd0);
    check("limit0_abort", busy, 1'b0);

    // Asynchronous reset mid-RUN
    send_cmd(4'd6, 32'd1000);
    do_start("s6");
    tick(15);
    check("s6_count", cand_count, 64'd60);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("arst");
    #2 reset = 1'b0;
    tick(2);
    check("post_arst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
